// File: rtl/led_pkg.sv
// Shared mode encoding for the LED mode sequencer and its helpers.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_BLINK;
      MODE_BLINK: return MODE_SHIFT;
      MODE_SHIFT: return MODE_COUNT;
      default:    return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter-based debounce and a one-cycle pulse on
// each accepted press; releases are filtered the same way but produce no pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic adv
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          btn_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = btn_s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      btn_s_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync1_q       <= btn;
      btn_s_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  assign adv = stable_q & ~stable_prev_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-selected LED pattern sequencer: single clock domain, a prescaler
// producing a one-cycle step strobe, and a four-mode pattern FSM.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int LEDS_NR        = 3,
  parameter int TICK_DIV       = 2250000,
  parameter int DEB_CYCLES     = 240000,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic               pause,
  output logic [LEDS_NR-1:0] led,
  output logic [MODE_W-1:0]  mode,
  output logic               tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [LEDS_NR-1:0] LED_POL    = {LEDS_NR{LED_ACTIVE_LOW != 0}};
  localparam logic [LEDS_NR-1:0] ONE_HOT0   = LEDS_NR'(1);

  logic               adv;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick_q, tick_d;
  mode_e              mode_q, mode_d;
  logic [LEDS_NR-1:0] pattern_q, pattern_d;
  logic               dir_up_q, dir_up_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .adv (adv)
  );

  // A mode change restarts the step period so every mode begins with a full interval.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (adv) begin
      presc_d = '0;
    end else if (!pause) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    if (adv) begin
      mode_d    = next_mode(mode_q);
      dir_up_d  = 1'b1;
      pattern_d = (mode_d == MODE_SHIFT) ? ONE_HOT0 : '0;
    end else if (tick_q) begin
      case (mode_q)
        MODE_BLINK: pattern_d = ~pattern_q;
        MODE_SHIFT: begin
          if (LEDS_NR == 1) begin
            pattern_d = pattern_q;
          end else if (dir_up_q) begin
            pattern_d = pattern_q << 1;
            if (pattern_d[LEDS_NR-1]) dir_up_d = 1'b0;
          end else begin
            pattern_d = pattern_q >> 1;
            if (pattern_d[0]) dir_up_d = 1'b1;
          end
        end
        MODE_COUNT: pattern_d = pattern_q + 1'b1;
        default:    pattern_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      mode_q    <= MODE_OFF;
      pattern_q <= '0;
      dir_up_q  <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign led  = pattern_q ^ LED_POL;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule
